// File: rtl/lfsr_pkg.sv
// Shared definitions for the 8-bit LFSR generator/checker family:
// feedback rule, marker constants and checker FSM encodings.
package lfsr_pkg;

  typedef enum logic [1:0] {
    HUNT    = 2'd0,
    LOCKING = 2'd1,
    LOCKED  = 2'd2,
    ILLEGAL = 2'd3
  } state_e;

  localparam logic [7:0] RESEED_MARK = 8'h80;
  localparam logic [7:0] LOCKUP      = 8'hFF;

  // XNOR feedback taps 8,6,5,4; all-ones is the lockup value.
  function automatic logic [7:0] lfsr_next(input logic [7:0] x);
    return {x[6:0], ~(x[7] ^ x[5] ^ x[4] ^ x[3])};
  endfunction

endpackage

// File: rtl/lfsr_8bit_next.sv
// Combinational next-value step of the 8-bit LFSR; shared with the generator.
module lfsr_8bit_next
  import lfsr_pkg::*;
(
  input  logic [7:0] value_i,
  output logic [7:0] next_o
);

  always_comb begin
    next_o = lfsr_next(value_i);
  end

endmodule

// File: rtl/lfsr_8bit_seq_checker.sv
// Receive-side checker: synchronises to an incoming 8-bit LFSR stream,
// flags and counts mismatches once locked, and honours 8'h80 reseed markers.
module lfsr_8bit_seq_checker
  import lfsr_pkg::*;
#(
  parameter int unsigned LOCK_COUNT = 4,
  parameter int unsigned LOSS_COUNT = 3
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        ce,
  input  logic [7:0]  din,
  input  logic        clr_cnt,
  output logic        locked,
  output logic        err_pulse,
  output logic [15:0] err_count,
  output logic        reseed_pulse,
  output logic [1:0]  state
);

  localparam int unsigned MW = $clog2(LOCK_COUNT + 1);
  localparam int unsigned LW = $clog2(LOSS_COUNT + 1);
  localparam logic [MW-1:0] LOCK_LAST = MW'(LOCK_COUNT - 1);
  localparam logic [LW-1:0] LOSS_LAST = LW'(LOSS_COUNT - 1);

  state_e        state_q;
  logic [7:0]    prev_q;
  logic [MW-1:0] match_cnt_q;
  logic [LW-1:0] miss_cnt_q;
  logic [15:0]   err_count_q;
  logic          err_pulse_q;
  logic          reseed_pulse_q;
  logic [7:0]    exp_val;
  logic          reseed_hit;

  lfsr_8bit_next u_next (
    .value_i (prev_q),
    .next_o  (exp_val)
  );

  assign reseed_hit = (prev_q == RESEED_MARK);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q        <= HUNT;
      prev_q         <= '0;
      match_cnt_q    <= '0;
      miss_cnt_q     <= '0;
      err_count_q    <= '0;
      err_pulse_q    <= 1'b0;
      reseed_pulse_q <= 1'b0;
    end else begin
      err_pulse_q    <= 1'b0;
      reseed_pulse_q <= 1'b0;
      if (clr_cnt) begin
        err_count_q <= '0;
      end
      case (state_q)
        HUNT: begin
          if (ce) begin
            prev_q      <= din;
            match_cnt_q <= '0;
            if (din != LOCKUP) begin
              state_q <= LOCKING;
            end
          end
        end
        LOCKING: begin
          if (ce) begin
            prev_q <= din;
            if (reseed_hit) begin
              reseed_pulse_q <= 1'b1;
            end else if (din == exp_val) begin
              match_cnt_q <= match_cnt_q + 1'b1;
              if (match_cnt_q == LOCK_LAST) begin
                state_q    <= LOCKED;
                miss_cnt_q <= '0;
              end
            end else begin
              match_cnt_q <= '0;
            end
          end
        end
        LOCKED: begin
          if (ce) begin
            if (reseed_hit) begin
              prev_q         <= din;
              reseed_pulse_q <= 1'b1;
            end else if (din == exp_val && din != LOCKUP) begin
              prev_q     <= din;
              miss_cnt_q <= '0;
            end else begin
              // Flywheel: keep tracking the expected sequence through errors.
              prev_q      <= exp_val;
              err_pulse_q <= 1'b1;
              miss_cnt_q  <= miss_cnt_q + 1'b1;
              if (!clr_cnt && err_count_q != 16'hFFFF) begin
                err_count_q <= err_count_q + 16'd1;
              end
              if (miss_cnt_q == LOSS_LAST) begin
                state_q <= HUNT;
              end
            end
          end
        end
        default: state_q <= HUNT;
      endcase
    end
  end

  assign locked       = (state_q == LOCKED);
  assign err_pulse    = err_pulse_q;
  assign err_count    = err_count_q;
  assign reseed_pulse = reseed_pulse_q;
  assign state        = state_q;

endmodule

// File: tb/tb_lfsr_8bit_seq_checker.sv
// Self-checking bench for lfsr_8bit_seq_checker: directed table, corner
// sequences, randomized stream against a behavioural model, saturation run.
module tb_lfsr_8bit_seq_checker;

  localparam int unsigned LOCK_COUNT = 4;
  localparam int unsigned LOSS_COUNT = 3;

  logic        clk = 1'b0;
  logic        reset;
  logic        ce, clr_cnt;
  logic [7:0]  din;
  logic        locked, err_pulse, reseed_pulse;
  logic [15:0] err_count;
  logic [1:0]  state;

  logic        ce2, clr2;
  logic [7:0]  din2;
  logic        locked2, err2, res2;
  logic [15:0] cnt2;
  logic [1:0]  st2;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  lfsr_8bit_seq_checker #(.LOCK_COUNT(LOCK_COUNT), .LOSS_COUNT(LOSS_COUNT)) dut (
    .clk(clk), .reset(reset), .ce(ce), .din(din), .clr_cnt(clr_cnt),
    .locked(locked), .err_pulse(err_pulse), .err_count(err_count),
    .reseed_pulse(reseed_pulse), .state(state)
  );

  lfsr_8bit_seq_checker #(.LOSS_COUNT(65540)) dut_sat (
    .clk(clk), .reset(reset), .ce(ce2), .din(din2), .clr_cnt(clr2),
    .locked(locked2), .err_pulse(err2), .err_count(cnt2),
    .reseed_pulse(res2), .state(st2)
  );

  // Behavioural model: mode 0 = hunting, 1 = acquiring, 2 = locked.
  int unsigned m_mode, m_prev, m_match, m_miss, m_cnt, m_err, m_res;

  function automatic int unsigned nxt(input int unsigned x);
    int unsigned ones;
    ones = ((x >> 7) & 1) + ((x >> 5) & 1) + ((x >> 4) & 1) + ((x >> 3) & 1);
    return ((x * 2) % 256) + ((ones % 2 == 0) ? 1 : 0);
  endfunction

  function automatic int unsigned prv(input int unsigned y);
    int unsigned top;
    top = ((1 - (y & 1)) + ((y >> 6) & 1) + ((y >> 5) & 1) + ((y >> 4) & 1)) % 2;
    return (y >> 1) + top * 128;
  endfunction

  task automatic model_reset();
    m_mode = 0; m_prev = 0; m_match = 0; m_miss = 0; m_cnt = 0; m_err = 0; m_res = 0;
  endtask

  task automatic model_step(input bit c, input int unsigned d, input bit clr);
    int unsigned e;
    m_err = 0;
    m_res = 0;
    e = nxt(m_prev);
    if (c) begin
      if (m_mode == 0) begin
        m_prev = d; m_match = 0;
        if (d != 255) m_mode = 1;
      end else if (m_prev == 128) begin
        m_prev = d; m_res = 1;
      end else if (m_mode == 1) begin
        if (d == e) begin
          m_match++;
          if (m_match == LOCK_COUNT) begin m_mode = 2; m_miss = 0; end
        end else m_match = 0;
        m_prev = d;
      end else if (d == e && d != 255) begin
        m_prev = d; m_miss = 0;
      end else begin
        m_err = 1;
        if (!clr && m_cnt < 65535) m_cnt++;
        m_miss++;
        m_prev = e;
        if (m_miss == LOSS_COUNT) m_mode = 0;
      end
    end
    if (clr) m_cnt = 0;
  endtask

  task automatic check(input string name, input int unsigned act, input int unsigned exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic check_model(input string tag);
    check({tag, ".locked"}, locked, (m_mode == 2) ? 1 : 0);
    check({tag, ".err_pulse"}, err_pulse, m_err);
    check({tag, ".err_count"}, err_count, m_cnt);
    check({tag, ".reseed_pulse"}, reseed_pulse, m_res);
    check({tag, ".state"}, state, m_mode);
  endtask

  task automatic apply(input bit c, input logic [7:0] d, input bit clr);
    ce = c; din = d; clr_cnt = clr;
    @(posedge clk);
    model_step(c, d, clr);
    #1;
  endtask

  task automatic apply2(input bit c, input logic [7:0] d);
    ce2 = c; din2 = d; clr2 = 1'b0;
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    bit          ce;
    logic [7:0]  din;
    bit          clr;
    bit          locked;
    bit          err;
    logic [15:0] cnt;
    bit          res;
    logic [1:0]  st;
  } vec_t;

  vec_t tbl[8];

  initial begin
    int unsigned s, d;
    tbl[0] = '{1'b1, 8'h01, 1'b0, 1'b0, 1'b0, 16'd0, 1'b0, 2'd1};
    tbl[1] = '{1'b1, 8'h03, 1'b0, 1'b0, 1'b0, 16'd0, 1'b0, 2'd1};
    tbl[2] = '{1'b1, 8'h07, 1'b0, 1'b0, 1'b0, 16'd0, 1'b0, 2'd1};
    tbl[3] = '{1'b1, 8'h0F, 1'b0, 1'b0, 1'b0, 16'd0, 1'b0, 2'd1};
    tbl[4] = '{1'b1, 8'h1E, 1'b0, 1'b1, 1'b0, 16'd0, 1'b0, 2'd2};
    tbl[5] = '{1'b1, 8'h3D, 1'b0, 1'b1, 1'b0, 16'd0, 1'b0, 2'd2};
    tbl[6] = '{1'b1, 8'h55, 1'b0, 1'b1, 1'b1, 16'd1, 1'b0, 2'd2};
    tbl[7] = '{1'b1, 8'hF4, 1'b0, 1'b1, 1'b0, 16'd1, 1'b0, 2'd2};

    reset = 1'b0; ce = 1'b0; din = '0; clr_cnt = 1'b0;
    ce2 = 1'b0; din2 = '0; clr2 = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_model("reset");
    reset = 1'b1;

    foreach (tbl[i]) begin
      apply(tbl[i].ce, tbl[i].din, tbl[i].clr);
      check($sformatf("tbl%0d.locked", i), locked, tbl[i].locked);
      check($sformatf("tbl%0d.err_pulse", i), err_pulse, tbl[i].err);
      check($sformatf("tbl%0d.err_count", i), err_count, tbl[i].cnt);
      check($sformatf("tbl%0d.reseed", i), reseed_pulse, tbl[i].res);
      check($sformatf("tbl%0d.state", i), state, tbl[i].st);
    end

    // Loss of lock after three consecutive wrong samples.
    apply(1'b1, 8'(nxt(m_prev)), 1'b1);
    check_model("clr");
    for (int i = 0; i < 3; i++) begin
      apply(1'b1, 8'(nxt(m_prev) ^ 1), 1'b0);
      check_model("loss");
    end
    check("loss.err_count", err_count, 3);
    check("loss.locked", locked, 0);
    check("loss.state", state, 0);

    apply(1'b1, 8'hFF, 1'b0);
    check("hunt_ff.state", state, 0);
    check_model("hunt_ff");

    // Acquire with a seed that walks into C0, so the next expected value is the marker.
    s = prv(prv(prv(prv(32'hC0))));
    apply(1'b1, 8'(s), 1'b0);
    for (int i = 0; i < 4; i++) begin
      apply(1'b1, 8'(nxt(m_prev)), 1'b0);
      check_model("seed");
    end
    check("seed.locked", locked, 1);
    apply(1'b1, 8'h80, 1'b0);
    check_model("mark");
    apply(1'b1, 8'h42, 1'b0);
    check("reseed.pulse", reseed_pulse, 1);
    check("reseed.err", err_pulse, 0);
    apply(1'b1, 8'h85, 1'b0);
    check("post_reseed.err", err_pulse, 0);
    check("post_reseed.locked", locked, 1);
    check("post_reseed.pulse", reseed_pulse, 0);

    for (int i = 0; i < 10; i++) begin
      apply(1'b0, 8'($urandom), 1'b0);
      check_model("ce_hold");
      check("ce_hold.locked", locked, 1);
    end
    apply(1'b1, 8'(nxt(m_prev)), 1'b0);
    check_model("resume");

    apply(1'b1, 8'(nxt(m_prev) ^ 8'h10), 1'b1);
    check("clr_err.pulse", err_pulse, 1);
    check("clr_err.count", err_count, 0);
    apply(1'b1, 8'(nxt(m_prev) ^ 8'h10), 1'b0);
    check_model("pre_rst");

    // Asynchronous reset between edges.
    #2 reset = 1'b0;
    #1;
    model_reset();
    check("async.locked", locked, 0);
    check("async.err_count", err_count, 0);
    check("async.state", state, 0);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;

    for (int i = 0; i < 600; i++) begin
      bit c, clr;
      int unsigned r;
      c = ($urandom % 5) != 0;
      r = $urandom % 100;
      if (r < 70)      d = nxt(m_prev);
      else if (r < 75) d = 255;
      else if (r < 80) d = 128;
      else             d = $urandom % 256;
      clr = ($urandom % 50) == 0;
      apply(c, 8'(d), clr);
      check_model("rand");
    end
    ce = 1'b0;

    // Saturation on an instance that never drops lock.
    apply2(1'b1, 8'h01);
    apply2(1'b1, 8'h03);
    apply2(1'b1, 8'h07);
    apply2(1'b1, 8'h0F);
    apply2(1'b1, 8'h1E);
    check("sat.lock", locked2, 1);
    for (int i = 0; i < 70000 && cnt2 != 16'hFFFF; i++) apply2(1'b1, 8'hFF);
    check("sat.reach", cnt2, 16'hFFFF);
    apply2(1'b1, 8'hFF);
    check("sat.hold", cnt2, 16'hFFFF);
    check("sat.pulse", err2, 1);
    check("sat.reseed", res2, 0);
    check("sat.state", st2, 2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
